// File: rtl/universal_shifter.sv
// ---------------------------------------------------------------------------
// universal_shifter
//
// Multi-cycle universal shift register. A command (LOAD, SHR, SHL, ROR, ROL,
// ASR) is accepted with start while not busy. A shift of k bits runs one bit
// per clock, and the register contents are always visible on Q.
//
// Configuration macro: UNIVERSAL_SHIFTER_ROTATE_EN
//   defined   : ROR (011) and ROL (100) rotate the register.
//   undefined : 011 and 100 are reserved one-cycle no-ops. No rotate logic
//               is built.
//
// Handshake: start is sampled on a rising edge only while the block is in
// IDLE or DONE (busy=0). A start seen while busy=1 is dropped, not queued.
// busy is high for exactly the k cycles of a k-bit shift. done is a
// one-cycle pulse in the cycle after the completing edge.
//
// Ports:
//   clk      in   clock; all state changes on the rising edge
//   clr      in   asynchronous active-low reset
//   start    in   command strobe
//   op       in   [2:0] command code
//   amt      in   [CNT_W-1:0] shift count, clamped to WIDTH
//   D        in   [WIDTH-1:0] parallel load data
//   D_sr     in   serial bit entering the MSB on SHR (sampled each step)
//   D_sl     in   serial bit entering the LSB on SHL (sampled each step)
//   Q        out  [WIDTH-1:0] register contents
//   busy     out  high while a shift is executing
//   done     out  one-cycle completion pulse
//   o_state  out  [1:0] debug view of the FSM (0 IDLE, 1 SHIFT, 2 DONE)
// ---------------------------------------------------------------------------
module universal_shifter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] amt,
    input  logic [WIDTH-1:0] D,
    input  logic             D_sr,
    input  logic             D_sl,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic [1:0]       o_state
);

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ASR  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] w_amt;
    logic [WIDTH-1:0] w_step;
    logic             w_accept;
    logic             w_is_shift;

    // A new command can be taken in IDLE and also in DONE, so that
    // back-to-back commands are possible.
    assign w_accept = start && (r_state != ST_SHIFT);

    // Counts above WIDTH would only repeat work, so clamp them.
    assign w_amt = (amt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amt;

    // Which op codes start a multi-cycle shift. Everything else except LOAD
    // completes as a one-cycle no-op.
    always_comb begin
        w_is_shift = 1'b0;
        case (op)
            OP_SHR, OP_SHL, OP_ASR: w_is_shift = 1'b1;
`ifdef UNIVERSAL_SHIFTER_ROTATE_EN
            OP_ROR, OP_ROL:         w_is_shift = 1'b1;
`endif
            default:                w_is_shift = 1'b0;
        endcase
    end

    // One-bit step for the captured op. The serial fill bits are read live.
    always_comb begin
        w_step = r_q;
        case (r_op)
            OP_SHR: w_step = {D_sr, r_q[WIDTH-1:1]};
            OP_SHL: w_step = {r_q[WIDTH-2:0], D_sl};
            OP_ASR: w_step = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
`ifdef UNIVERSAL_SHIFTER_ROTATE_EN
            OP_ROR: w_step = {r_q[0], r_q[WIDTH-1:1]};
            OP_ROL: w_step = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
`endif
            default: w_step = r_q;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    if (w_is_shift && (w_amt != '0)) begin
                        w_next = ST_SHIFT;
                    end else begin
                        w_next = ST_DONE;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // The step that takes the counter from 1 to 0 is the last one.
                if (r_cnt == CNT_W'(1)) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_SHIFT;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_IDLE;
            r_op    <= OP_LOAD;
            r_cnt   <= '0;
            r_q     <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op <= op;
                if (op == OP_LOAD) begin
                    r_q <= D;
                end else if (w_is_shift) begin
                    r_cnt <= w_amt;
                end
            end else if (r_state == ST_SHIFT) begin
                r_q   <= w_step;
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign Q       = r_q;
    assign busy    = (r_state == ST_SHIFT);
    assign done    = (r_state == ST_DONE);
    assign o_state = r_state;

endmodule

// File: tb/tb_universal_shifter.sv
// Directed bench for universal_shifter with WIDTH=8. Inputs change on the
// falling edge and outputs are sampled there as well, half a cycle away from
// the active rising edge.
module tb_universal_shifter;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic             clk;
  logic             clr;
  logic             start;
  logic [2:0]       op;
  logic [CNT_W-1:0] amt;
  logic [WIDTH-1:0] d;
  logic             d_sr;
  logic             d_sl;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  int n_vec;
  int n_err;
  int n_busy;

  universal_shifter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .op      (op),
    .amt     (amt),
    .D       (d),
    .D_sr    (d_sr),
    .D_sl    (d_sl),
    .Q       (q),
    .busy    (busy),
    .done    (done),
    .o_state (state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command at a falling edge, let the next rising edge (E0) take
  // it, and return at the following falling edge with start dropped.
  task automatic issue(input logic [2:0] c_op, input logic [CNT_W-1:0] c_amt,
                       input logic [WIDTH-1:0] c_d);
    start = 1'b1;
    op    = c_op;
    amt   = c_amt;
    d     = c_d;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clr = 1'b0; start = 1'b0; op = 3'b000; amt = '0; d = '0; d_sr = 1'b0; d_sl = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_q", q, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_state", state, S_IDLE);
    clr = 1'b1;
    @(negedge clk);

    // LOAD A5
    issue(3'b000, 4'd0, 8'hA5);
    check("load_q", q, 8'hA5);
    check("load_done", done, 1'b1);
    check("load_busy", busy, 1'b0);
    check("load_state", state, S_DONE);
    @(negedge clk);
    check("load_done_drop", done, 1'b0);
    check("load_idle", state, S_IDLE);

    // SHR by 3 with serial fill 1,0,1
    issue(3'b001, 4'd3, 8'h00);
    check("shr_busy0", busy, 1'b1);
    check("shr_q0", q, 8'hA5);
    d_sr = 1'b1;
    @(negedge clk);
    check("shr_q1", q, 8'hD2);
    check("shr_busy1", busy, 1'b1);
    d_sr = 1'b0;
    @(negedge clk);
    check("shr_q2", q, 8'h69);
    check("shr_busy2", busy, 1'b1);
    d_sr = 1'b1;
    @(negedge clk);
    check("shr_q3", q, 8'hB4);
    check("shr_busy3", busy, 1'b0);
    check("shr_done", done, 1'b1);
    @(negedge clk);
    check("shr_done_drop", done, 1'b0);

    // ASR with amt=15 clamps to 8 steps
    issue(3'b000, 4'd0, 8'h80);
    @(negedge clk);
    issue(3'b101, 4'd15, 8'h00);
    n_busy = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy) n_busy++;
      @(negedge clk);
    end
    check("asr_busy_cycles", n_busy, 8);
    check("asr_q", q, 8'hFF);
    check("asr_done", done, 1'b1);
    check("asr_busy_end", busy, 1'b0);
    @(negedge clk);

    // ROL by 1 from 81
    issue(3'b000, 4'd0, 8'h81);
    @(negedge clk);
    issue(3'b100, 4'd1, 8'h00);
`ifdef UNIVERSAL_SHIFTER_ROTATE_EN
    check("rol_busy", busy, 1'b1);
    @(negedge clk);
    check("rol_q", q, 8'h03);
    check("rol_done", done, 1'b1);
`else
    check("rol_q", q, 8'h81);
    check("rol_done", done, 1'b1);
    check("rol_busy", busy, 1'b0);
`endif
    @(negedge clk);

    // SHL by 4 with a start while busy, then a back-to-back LOAD
    issue(3'b000, 4'd0, 8'hFF);
    @(negedge clk);
    d_sl = 1'b0;
    issue(3'b010, 4'd4, 8'h00);
    check("shl_busy", busy, 1'b1);
    start = 1'b1; op = 3'b000; d = 8'h00;
    @(negedge clk);
    start = 1'b0;
    check("shl_ignore_q1", q, 8'hFE);
    check("shl_ignore_busy", busy, 1'b1);
    @(negedge clk);
    check("shl_q2", q, 8'hFC);
    @(negedge clk);
    check("shl_q3", q, 8'hF8);
    @(negedge clk);
    check("shl_q4", q, 8'hF0);
    check("shl_done", done, 1'b1);
    issue(3'b000, 4'd0, 8'h3C);
    check("b2b_q", q, 8'h3C);
    check("b2b_done", done, 1'b1);
    check("b2b_state", state, S_DONE);
    @(negedge clk);

    // reset in the middle of a SHL by 6
    issue(3'b000, 4'd0, 8'hFF);
    @(negedge clk);
    issue(3'b010, 4'd6, 8'h00);
    @(negedge clk);
    check("mid_q1", q, 8'hFE);
    @(negedge clk);
    check("mid_q2", q, 8'hFC);
    clr = 1'b0;
    #1;
    check("mid_rst_q", q, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_state", state, S_IDLE);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check("post_rst_done", done, 1'b0);
    check("post_rst_state", state, S_IDLE);
    issue(3'b000, 4'd0, 8'h5A);
    check("post_rst_load_q", q, 8'h5A);
    check("post_rst_load_done", done, 1'b1);
    @(negedge clk);

    // shift with amt=0 and a reserved op both complete as no-ops
    issue(3'b001, 4'd0, 8'h00);
    check("amt0_q", q, 8'h5A);
    check("amt0_done", done, 1'b1);
    check("amt0_busy", busy, 1'b0);
    @(negedge clk);
    issue(3'b110, 4'd5, 8'h00);
    check("rsv_q", q, 8'h5A);
    check("rsv_done", done, 1'b1);
    check("rsv_busy", busy, 1'b0);
    @(negedge clk);
    check("final_idle", state, S_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
